// File: rtl/multicycle_shifter.sv
// Multi-cycle barrel-free shifter: shifts/rotates opd1 by shamt, up to STEP bits per cycle.
// Operands are captured on start; result and op_error are registered on entry to DONE.
module multicycle_shifter #(
    parameter int unsigned OPD_LENGTH = 32,
    parameter int unsigned STEP       = 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic [OPD_LENGTH-1:0] opd1,
    input  logic [OPD_LENGTH-1:0] opd2,
    input  logic [2:0]            alu_op_select,
    output logic                  busy,
    output logic                  done,
    output logic [OPD_LENGTH-1:0] shifter_result,
    output logic                  op_error
);

    localparam int unsigned SH_W = $clog2(OPD_LENGTH);

    localparam logic [2:0] OP_SRL = 3'b001;
    localparam logic [2:0] OP_SLL = 3'b011;
    localparam logic [2:0] OP_SRA = 3'b111;
    localparam logic [2:0] OP_ROR = 3'b101;
    localparam logic [2:0] OP_ROL = 3'b110;

    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

    state_t                state;
    logic [OPD_LENGTH-1:0] work;
    logic [SH_W-1:0]       remaining;
    logic [2:0]            op;
    logic [SH_W-1:0]       shamt;
    logic [SH_W-1:0]       step_amt;
    logic [OPD_LENGTH-1:0] work_next;
    logic                  start_valid;
    logic                  unused_opd2_hi;

    assign shamt          = opd2[SH_W-1:0];
    assign unused_opd2_hi = ^opd2[OPD_LENGTH-1:SH_W];

    function automatic logic is_valid(input logic [2:0] code);
        case (code)
            OP_SRL, OP_SLL, OP_SRA, OP_ROR, OP_ROL: return 1'b1;
            default:                                return 1'b0;
        endcase
    endfunction

    assign start_valid = is_valid(alu_op_select);

    // One shift step of min(STEP, remaining); step_amt is never 0 while in SHIFT.
    always_comb begin
        step_amt = remaining;
        if (32'(remaining) > STEP) begin
            step_amt = SH_W'(STEP);
        end
        work_next = work;
        case (op)
            OP_SRL:  work_next = work >> step_amt;
            OP_SLL:  work_next = work << step_amt;
            OP_SRA:  work_next = OPD_LENGTH'($signed(work) >>> step_amt);
            OP_ROR:  work_next = (work >> step_amt) | (work << (OPD_LENGTH - 32'(step_amt)));
            OP_ROL:  work_next = (work << step_amt) | (work >> (OPD_LENGTH - 32'(step_amt)));
            default: work_next = work;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state          <= IDLE;
            busy           <= 1'b0;
            done           <= 1'b0;
            shifter_result <= '0;
            op_error       <= 1'b0;
            work           <= '0;
            remaining      <= '0;
            op             <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        work      <= opd1;
                        remaining <= shamt;
                        op        <= alu_op_select;
                        busy      <= 1'b1;
                        if (start_valid && (shamt != '0)) begin
                            state <= SHIFT;
                        end else begin
                            // Nothing to shift: complete immediately with passthrough or error.
                            state          <= DONE;
                            done           <= 1'b1;
                            shifter_result <= start_valid ? opd1 : '0;
                            op_error       <= ~start_valid;
                        end
                    end
                end
                SHIFT: begin
                    work      <= work_next;
                    remaining <= remaining - step_amt;
                    if (remaining == step_amt) begin
                        state          <= DONE;
                        done           <= 1'b1;
                        shifter_result <= work_next;
                        op_error       <= 1'b0;
                    end
                end
                DONE: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                    done  <= 1'b0;
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                    done  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_multicycle_shifter.sv
// Bench for multicycle_shifter: STEP=1 and STEP=4 instances, scoreboard of expected completions.
module tb_multicycle_shifter;

    localparam logic [2:0] SRL = 3'b001;
    localparam logic [2:0] SLL = 3'b011;
    localparam logic [2:0] SRA = 3'b111;
    localparam logic [2:0] ROR = 3'b101;
    localparam logic [2:0] ROL = 3'b110;

    logic        clk = 1'b0;
    logic        rst_n, start1, start4;
    logic [31:0] opd1, opd2;
    logic [2:0]  op_sel;
    logic        busy1, done1, err1, busy4, done4, err4;
    logic [31:0] res1, res4;

    always #5 clk = ~clk;

    multicycle_shifter #(.OPD_LENGTH(32), .STEP(1)) u1 (
        .clk(clk), .rst_n(rst_n), .start(start1), .opd1(opd1), .opd2(opd2),
        .alu_op_select(op_sel), .busy(busy1), .done(done1),
        .shifter_result(res1), .op_error(err1)
    );

    multicycle_shifter #(.OPD_LENGTH(32), .STEP(4)) u4 (
        .clk(clk), .rst_n(rst_n), .start(start4), .opd1(opd1), .opd2(opd2),
        .alu_op_select(op_sel), .busy(busy4), .done(done4),
        .shifter_result(res4), .op_error(err4)
    );

    typedef struct {
        logic [31:0] res;
        logic        err;
        int          cyc;
    } exp_t;

    exp_t q1[$];
    exp_t q4[$];
    int   n_chk = 0;
    int   n_fail = 0;
    int   cyc = 0;
    int   done_cnt1 = 0;
    int   done_cnt4 = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic bit op_valid(input logic [2:0] op);
        return (op == SRL) || (op == SLL) || (op == SRA) || (op == ROR) || (op == ROL);
    endfunction

    // Bit-by-bit reference of the full shift in one step.
    function automatic logic [31:0] ref_shift(input logic [2:0] op, input logic [31:0] a, input int sh);
        logic [31:0] r;
        r = '0;
        for (int i = 0; i < 32; i++) begin
            case (op)
                SRL:     r[i] = (i + sh < 32) ? a[i + sh] : 1'b0;
                SLL:     r[i] = (i >= sh) ? a[i - sh] : 1'b0;
                SRA:     r[i] = (i + sh < 32) ? a[i + sh] : a[31];
                ROR:     r[i] = a[(i + sh) % 32];
                ROL:     r[i] = a[(i - sh + 32) % 32];
                default: r[i] = 1'b0;
            endcase
        end
        return r;
    endfunction

    function automatic int latency(input int step, input logic [2:0] op, input int sh);
        if (!op_valid(op) || sh == 0) return 1;
        return 1 + (sh + step - 1) / step;
    endfunction

    // Completion monitor: every done pulse must match the oldest expectation.
    always @(negedge clk) begin
        exp_t e;
        if (done1) begin
            done_cnt1++;
            if (q1.size() == 0) chk("u1_unexpected_done", 64'(done1), 64'(0));
            else begin
                e = q1.pop_front();
                chk("u1_result", 64'(res1), 64'(e.res));
                chk("u1_op_error", 64'(err1), 64'(e.err));
                chk("u1_done_cycle", 64'(cyc), 64'(e.cyc));
            end
        end
        if (done4) begin
            done_cnt4++;
            if (q4.size() == 0) chk("u4_unexpected_done", 64'(done4), 64'(0));
            else begin
                e = q4.pop_front();
                chk("u4_result", 64'(res4), 64'(e.res));
                chk("u4_op_error", 64'(err4), 64'(e.err));
                chk("u4_done_cycle", 64'(cyc), 64'(e.cyc));
            end
        end
    end

    task automatic push(input bit sel4, input logic [2:0] op, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] res);
        exp_t e;
        e.res = res;
        e.err = !op_valid(op);
        e.cyc = cyc + latency(sel4 ? 4 : 1, op, int'(b[4:0]));
        if (sel4) q4.push_back(e);
        else q1.push_back(e);
    endtask

    // Wait (bounded) for the scoreboard to empty, checking busy along the way and result hold after.
    task automatic drain(input bit sel4, input logic [31:0] res);
        int n;
        for (n = 0; n < 60; n++) begin
            @(posedge clk); #2;
            if ((sel4 ? q4.size() : q1.size()) == 0) break;
            chk(sel4 ? "u4_busy" : "u1_busy", 64'(sel4 ? busy4 : busy1), 64'(1));
        end
        if (n == 60) begin
            chk("drain_timeout", 64'(sel4 ? q4.size() : q1.size()), 64'(0));
            q1.delete();
            q4.delete();
        end
        chk(sel4 ? "u4_idle" : "u1_idle", 64'(sel4 ? busy4 : busy1), 64'(0));
        chk(sel4 ? "u4_hold" : "u1_hold", 64'(sel4 ? res4 : res1), 64'(res));
    endtask

    task automatic run_chk(input bit sel4, input logic [2:0] op, input logic [31:0] a,
                           input logic [31:0] b, input logic [31:0] res);
        opd1 = a; opd2 = b; op_sel = op;
        push(sel4, op, a, b, res);
        if (sel4) start4 = 1'b1;
        else start1 = 1'b1;
        @(posedge clk); #2;
        start1 = 1'b0; start4 = 1'b0;
        opd1 = ~a; opd2 = $urandom; op_sel = 3'($urandom);
        chk(sel4 ? "u4_busy_first" : "u1_busy_first", 64'(sel4 ? busy4 : busy1), 64'(1));
        drain(sel4, res);
    endtask

    task automatic run(input bit sel4, input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        run_chk(sel4, op, a, b, ref_shift(op, a, int'(b[4:0])));
    endtask

    initial begin
        logic [2:0]  ops [7];
        logic [31:0] r;
        int          d0;
        ops = '{SRL, SLL, SRA, ROR, ROL, 3'b010, 3'b100};
        rst_n = 1'b0; start1 = 1'b0; start4 = 1'b0;
        opd1 = '0; opd2 = '0; op_sel = '0;
        repeat (2) @(posedge clk);
        #2;
        chk("rst_busy1", 64'(busy1), 64'(0));
        chk("rst_done1", 64'(done1), 64'(0));
        chk("rst_err1", 64'(err1), 64'(0));
        chk("rst_res1", 64'(res1), 64'(0));
        chk("rst_busy4", 64'(busy4), 64'(0));
        chk("rst_done4", 64'(done4), 64'(0));
        chk("rst_err4", 64'(err4), 64'(0));
        chk("rst_res4", 64'(res4), 64'(0));
        rst_n = 1'b1;
        @(posedge clk); #2;

        run_chk(1'b0, SRL, 32'h8000_0000, 32'd4, 32'h0800_0000);
        run_chk(1'b0, SRA, 32'h8000_0000, 32'h24, 32'hF800_0000);
        run_chk(1'b1, ROL, 32'h1234_5678, 32'd8, 32'h3456_7812);
        run_chk(1'b1, SLL, 32'h0000_0003, 32'd31, 32'h8000_0000);
        run_chk(1'b0, 3'b000, 32'hFFFF_FFFF, 32'h1234, 32'h0);
        run_chk(1'b0, SLL, 32'hA5A5_0F0F, 32'd0, 32'hA5A5_0F0F);
        run(1'b1, ROR, 32'hC001_D00D, 32'd31);
        run(1'b0, SRA, 32'h8000_0001, 32'd31);
        run(1'b1, ROL, 32'h0000_0001, 32'd5);
        for (int i = 0; i < 14; i++) begin
            run(1'(i % 2), ops[$urandom_range(0, 6)], $urandom, $urandom);
        end

        // start held high with inputs changing during SHIFT: one completion, then a fresh capture.
        opd1 = 32'h0000_00F1; opd2 = 32'd6; op_sel = SLL;
        d0 = done_cnt1;
        push(1'b0, SLL, 32'h0000_00F1, 32'd6, ref_shift(SLL, 32'h0000_00F1, 6));
        start1 = 1'b1;
        @(posedge clk); #2;
        opd1 = 32'hDEAD_BEEF; opd2 = 32'd3; op_sel = ROR;
        repeat (7) @(posedge clk);
        #2;
        chk("u1_single_done", 64'(done_cnt1 - d0), 64'(1));
        r = ref_shift(ROR, 32'hDEAD_BEEF, 3);
        push(1'b0, ROR, 32'hDEAD_BEEF, 32'd3, r);
        @(posedge clk); #2;
        start1 = 1'b0;
        drain(1'b0, r);

        // Reset mid-SHIFT aborts without a done pulse.
        opd1 = 32'h0F0F_1234; opd2 = 32'd10; op_sel = SRL;
        start1 = 1'b1;
        @(posedge clk); #2;
        start1 = 1'b0;
        repeat (3) @(posedge clk);
        #2;
        d0 = done_cnt1;
        rst_n = 1'b0;
        @(posedge clk); #2;
        rst_n = 1'b1;
        chk("abort_busy", 64'(busy1), 64'(0));
        chk("abort_done", 64'(done1), 64'(0));
        chk("abort_err", 64'(err1), 64'(0));
        chk("abort_res", 64'(res1), 64'(0));
        repeat (14) @(posedge clk);
        #2;
        chk("abort_no_done", 64'(done_cnt1 - d0), 64'(0));
        run(1'b0, ROL, 32'h0F0F_1234, 32'd10);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
